// File: rtl/fetch_stage_pkg.sv
// Shared fetch definitions: PC_sel encodings, address-region codes, bubble instruction, fetch FSM states.
package fetch_stage_pkg;

  localparam logic [2:0] PC_SEL_RESET = 3'd0;
  localparam logic [2:0] PC_SEL_HOLD  = 3'd1;
  localparam logic [2:0] PC_SEL_PLUS4 = 3'd2;
  localparam logic [2:0] PC_SEL_ALU   = 3'd3;
  localparam logic [2:0] PC_SEL_JAL   = 3'd4;

  localparam logic [3:0] REGION_BIOS = 4'b0100;
  localparam logic [3:0] REGION_IMEM = 4'b0001;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BIOS = 2'd1,
    SRC_IMEM = 2'd2
  } fetch_src_t;

  function automatic fetch_src_t region_of(input logic [31:0] addr);
    case (addr[31:28])
      REGION_BIOS: return SRC_BIOS;
      REGION_IMEM: return SRC_IMEM;
      default:     return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pc_mux.sv
// Combinational next-fetch-address select with word alignment.
// Boot forces RESET_PC; stall re-issues pc_q and overrides any redirect.
module fetch_pc_mux
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        boot,
  input  logic        stall,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] pc_q,
  input  logic [31:0] alu_result,
  input  logic [31:0] jal_target,
  output logic [31:0] fetch_addr
);

  logic [31:0] next_pc;

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (boot) begin
      next_pc = RESET_PC;
    end else if (stall) begin
      next_pc = pc_q;
    end else begin
      case (pc_sel)
        PC_SEL_RESET: next_pc = RESET_PC;
        PC_SEL_HOLD:  next_pc = pc_q;
        PC_SEL_ALU:   next_pc = alu_result;
        PC_SEL_JAL:   next_pc = jal_target;
        default:      next_pc = pc_q + 32'd4;
      endcase
    end
    fetch_addr = {next_pc[31:2], 2'b00};
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues BIOS/IMEM reads; FETCH_COUNTER_EN adds fetch/redirect counters.
// Latency: address issued in cycle t shows on pc_out/inst_out in t+1; redirects cost no bubble.
// Backpressure: stall re-issues pc_q so pc_out/inst_out hold for as long as stall is high.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [2:0]         PC_sel,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        jal_target,
  input  logic [31:0]        bios_dout,
  input  logic [31:0]        imem_dout,
  output logic [BIOS_AW-1:0] bios_addr,
  output logic               bios_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  output logic [31:0]        pc_out,
  output logic [31:0]        inst_out,
`ifdef FETCH_COUNTER_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        redirect_cnt,
`endif
  output logic               inst_valid
);

  import fetch_stage_pkg::fetch_state_t;
  import fetch_stage_pkg::fetch_src_t;
  import fetch_stage_pkg::ST_BOOT;
  import fetch_stage_pkg::ST_RUN;
  import fetch_stage_pkg::SRC_NONE;
  import fetch_stage_pkg::SRC_BIOS;
  import fetch_stage_pkg::SRC_IMEM;
  import fetch_stage_pkg::region_of;

  fetch_state_t state_q;
  fetch_src_t   src_q;
  fetch_src_t   src_d;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_addr;

  fetch_pc_mux #(.RESET_PC(RESET_PC)) u_pc_mux (
    .boot       (state_q == ST_BOOT),
    .stall      (stall),
    .pc_sel     (PC_sel),
    .pc_q       (pc_q),
    .alu_result (alu_result),
    .jal_target (jal_target),
    .fetch_addr (fetch_addr)
  );

  assign src_d = region_of(fetch_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= ST_RUN;
      pc_q    <= fetch_addr;
      src_q   <= src_d;
    end
  end

  // Memory ports stay quiet while reset is asserted; the BOOT cycle issues RESET_PC.
  assign bios_en   = rst && (src_d == SRC_BIOS);
  assign imem_en   = rst && (src_d == SRC_IMEM);
  assign bios_addr = rst ? fetch_addr[BIOS_AW+1:2] : '0;
  assign imem_addr = rst ? fetch_addr[IMEM_AW+1:2] : '0;

  assign pc_out     = pc_q;
  assign inst_valid = (state_q == ST_RUN) && (src_q != SRC_NONE);

  always_comb begin
    inst_out = NOP_INST;
    case (src_q)
      SRC_BIOS: inst_out = bios_dout;
      SRC_IMEM: inst_out = imem_dout;
      default:  inst_out = NOP_INST;
    endcase
  end

`ifdef FETCH_COUNTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else if (state_q == ST_RUN && !stall) begin
      if (inst_valid) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (PC_sel == fetch_stage_pkg::PC_SEL_ALU || PC_sel == fetch_stage_pkg::PC_SEL_JAL) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus reset sequences.
module tb_fetch_stage;

  localparam logic [31:0] BIOS_TAG = 32'hB105_0000;
  localparam logic [31:0] IMEM_TAG = 32'h1EE0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  PC_sel = 3'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] jal_target = 32'd0;
  logic [31:0] bios_dout = 32'd0;
  logic [31:0] imem_dout = 32'd0;
  logic [11:0] bios_addr;
  logic        bios_en;
  logic [13:0] imem_addr;
  logic        imem_en;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;
`ifdef FETCH_COUNTER_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .PC_sel       (PC_sel),
    .alu_result   (alu_result),
    .jal_target   (jal_target),
    .bios_dout    (bios_dout),
    .imem_dout    (imem_dout),
    .bios_addr    (bios_addr),
    .bios_en      (bios_en),
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .pc_out       (pc_out),
    .inst_out     (inst_out),
`ifdef FETCH_COUNTER_EN
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt),
`endif
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: each word reads back as TAG | word address.
  always @(posedge clk) begin
    if (bios_en) bios_dout <= BIOS_TAG | {20'd0, bios_addr};
    if (imem_en) imem_dout <= IMEM_TAG | {18'd0, imem_addr};
  end

  typedef struct {
    logic        st;
    logic [2:0]  sel;
    logic [31:0] alu;
    logic [31:0] jal;
    logic        ben;
    logic        ien;
    logic [11:0] ba;
    logic [13:0] ia;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        vld;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic st, input logic [2:0] sel, input logic [31:0] alu,
                              input logic [31:0] jal, input logic ben, input logic ien,
                              input logic [11:0] ba, input logic [13:0] ia, input logic [31:0] pc,
                              input logic [31:0] inst, input logic vld);
    vec_t v;
    v.st = st; v.sel = sel; v.alu = alu; v.jal = jal; v.ben = ben; v.ien = ien;
    v.ba = ba; v.ia = ia; v.pc = pc; v.inst = inst; v.vld = vld;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input logic ben, input logic ien, input logic [11:0] ba,
                             input logic [13:0] ia, input logic [31:0] pc, input logic [31:0] inst,
                             input logic vld);
    chk("bios_en",    idx, {31'd0, bios_en},    {31'd0, ben});
    chk("imem_en",    idx, {31'd0, imem_en},    {31'd0, ien});
    chk("bios_addr",  idx, {20'd0, bios_addr},  {20'd0, ba});
    chk("imem_addr",  idx, {18'd0, imem_addr},  {18'd0, ia});
    chk("pc_out",     idx, pc_out,              pc);
    chk("inst_out",   idx, inst_out,            inst);
    chk("inst_valid", idx, {31'd0, inst_valid}, {31'd0, vld});
  endtask

  initial begin
    // Cycle 0 is BOOT: stall and PC_sel=3 must be ignored.
    vecs[0]  = mk(1, 3, 32'hDEAD_BEEF, 0,            1, 0, 12'h000, 14'h0000, 32'h4000_0000, NOP,           0);
    vecs[1]  = mk(0, 2, 0, 0,                        1, 0, 12'h001, 14'h0001, 32'h4000_0000, 32'hB105_0000, 1);
    vecs[2]  = mk(0, 2, 0, 0,                        1, 0, 12'h002, 14'h0002, 32'h4000_0004, 32'hB105_0001, 1);
    vecs[3]  = mk(0, 2, 0, 0,                        1, 0, 12'h003, 14'h0003, 32'h4000_0008, 32'hB105_0002, 1);
    vecs[4]  = mk(0, 2, 0, 0,                        1, 0, 12'h004, 14'h0004, 32'h4000_000C, 32'hB105_0003, 1);
    vecs[5]  = mk(0, 3, 32'h1000_0102, 0,            0, 1, 12'h040, 14'h0040, 32'h4000_0010, 32'hB105_0004, 1);
    vecs[6]  = mk(0, 2, 0, 0,                        0, 1, 12'h041, 14'h0041, 32'h1000_0100, 32'h1EE0_0040, 1);
    vecs[7]  = mk(1, 4, 0, 32'h1000_0040,            0, 1, 12'h041, 14'h0041, 32'h1000_0104, 32'h1EE0_0041, 1);
    vecs[8]  = mk(1, 4, 0, 32'h1000_0040,            0, 1, 12'h041, 14'h0041, 32'h1000_0104, 32'h1EE0_0041, 1);
    vecs[9]  = mk(1, 4, 0, 32'h1000_0040,            0, 1, 12'h041, 14'h0041, 32'h1000_0104, 32'h1EE0_0041, 1);
    vecs[10] = mk(0, 4, 0, 32'h1000_0040,            0, 1, 12'h010, 14'h0010, 32'h1000_0104, 32'h1EE0_0041, 1);
    vecs[11] = mk(0, 2, 0, 0,                        0, 1, 12'h011, 14'h0011, 32'h1000_0040, 32'h1EE0_0010, 1);
    vecs[12] = mk(0, 3, 32'h2000_0003, 0,            0, 0, 12'h000, 14'h0000, 32'h1000_0044, 32'h1EE0_0011, 1);
    vecs[13] = mk(0, 1, 0, 0,                        0, 0, 12'h000, 14'h0000, 32'h2000_0000, NOP,           0);
    vecs[14] = mk(0, 0, 0, 0,                        1, 0, 12'h000, 14'h0000, 32'h2000_0000, NOP,           0);
    vecs[15] = mk(0, 5, 0, 0,                        1, 0, 12'h001, 14'h0001, 32'h4000_0000, 32'hB105_0000, 1);
    vecs[16] = mk(0, 3, 32'hFFFF_FFFE, 0,            0, 0, 12'hFFF, 14'h3FFF, 32'h4000_0004, 32'hB105_0001, 1);
    vecs[17] = mk(0, 2, 0, 0,                        0, 0, 12'h000, 14'h0000, 32'hFFFF_FFFC, NOP,           0);
    vecs[18] = mk(0, 4, 0, 32'h1000_0041,            0, 1, 12'h010, 14'h0010, 32'h0000_0000, NOP,           0);
    vecs[19] = mk(0, 7, 0, 0,                        0, 1, 12'h011, 14'h0011, 32'h1000_0040, 32'h1EE0_0010, 1);

    // Held in reset.
    @(negedge clk);
    chk_outputs(100, 0, 0, 12'h000, 14'h0000, 32'h4000_0000, NOP, 0);
`ifdef FETCH_COUNTER_EN
    chk("fetch_cnt_rst",    100, fetch_cnt,    32'd0);
    chk("redirect_cnt_rst", 100, redirect_cnt, 32'd0);
`endif

    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      stall      = vecs[i].st;
      PC_sel     = vecs[i].sel;
      alu_result = vecs[i].alu;
      jal_target = vecs[i].jal;
      @(negedge clk);
      chk_outputs(i, vecs[i].ben, vecs[i].ien, vecs[i].ba, vecs[i].ia, vecs[i].pc, vecs[i].inst, vecs[i].vld);
    end

`ifdef FETCH_COUNTER_EN
    chk("fetch_cnt",    19, fetch_cnt,    32'd11);
    chk("redirect_cnt", 19, redirect_cnt, 32'd5);
`endif

    // Asynchronous reset mid-run while pc_out = 1000_0040.
    #2;
    rst = 1'b0;
    #1;
    chk_outputs(200, 0, 0, 12'h000, 14'h0000, 32'h4000_0000, NOP, 0);
`ifdef FETCH_COUNTER_EN
    chk("fetch_cnt_midrst",    200, fetch_cnt,    32'd0);
    chk("redirect_cnt_midrst", 200, redirect_cnt, 32'd0);
`endif

    @(posedge clk);
    #1;
    rst        = 1'b1;
    stall      = 1'b0;
    PC_sel     = 3'd2;
    alu_result = 32'd0;
    jal_target = 32'd0;
    @(negedge clk);
    chk_outputs(201, 1, 0, 12'h000, 14'h0000, 32'h4000_0000, NOP, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_outputs(202, 1, 0, 12'h001, 14'h0001, 32'h4000_0000, 32'hB105_0000, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
